// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, sync length and FSM state type for the multiplier sequencer
package mul_pkg;
    localparam int WIDTH_LOG   = 4;
    localparam int WIDTH       = 1 << WIDTH_LOG;
    localparam int OUT_WIDTH   = 2 * WIDTH;
    localparam int SYNC_CYCLES = WIDTH + 4;

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DRAIN = 3'd4
    } seq_state_t;
endpackage

// File: rtl/mul_seq_fifo.sv
// rtl/mul_seq_fifo.sv - synchronous operand FIFO with wrap-bit pointers
module mul_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [DW-1:0] mem [DEPTH];

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequencer feeding an external shift-and-add multiplier; MUL_SEQ_ZERO_BYPASS_EN skips zero operands
module mul_seq
    import mul_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_o,
    output logic                 mul_in_valid,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_o,
    input  logic                 mul_out_valid,
    output logic                 seq_busy
);
    localparam int SYNC_N = WIDTH + 4;
    localparam int CW     = $clog2(SYNC_N);
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_N - 1);

    seq_state_t           state;
    seq_state_t           state_n;
    logic [CW-1:0]        sync_cnt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [2*WIDTH-1:0]   head;
    logic [WIDTH-1:0]     head_a;
    logic [WIDTH-1:0]     head_b;
    logic                 load_ops;
    logic                 capture;
    logic                 zero_wr;

    assign in_ready = !fifo_full && !rst;
    assign head_a   = head[2*WIDTH-1:WIDTH];
    assign head_b   = head[WIDTH-1:0];
    assign seq_busy = rst || (state != S_IDLE) || !fifo_empty;

    mul_seq_fifo #(
        .DEPTH (DEPTH),
        .DW    (2*WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && in_ready),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_n      = state;
        fifo_pop     = 1'b0;
        load_ops     = 1'b0;
        capture      = 1'b0;
        zero_wr      = 1'b0;
        mul_in_valid = 1'b0;
        case (state)
            S_SYNC: begin
                if (sync_cnt == SYNC_LAST) state_n = S_IDLE;
            end
            S_IDLE: begin
                // A full slot blocks issue even on its pop cycle, so capture never races a pop.
                if (!fifo_empty && !res_valid) begin
                    fifo_pop = 1'b1;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
                    if (head_a == '0 || head_b == '0) begin
                        zero_wr = 1'b1;
                    end else begin
                        load_ops = 1'b1;
                        state_n  = S_ISSUE;
                    end
`else
                    load_ops = 1'b1;
                    state_n  = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                mul_in_valid = 1'b1;
                state_n      = S_WAIT;
            end
            S_WAIT: begin
                if (mul_out_valid) begin
                    capture = 1'b1;
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // out_valid may stay up a second cycle; wait it out before the next issue.
                if (!mul_out_valid) state_n = S_IDLE;
            end
            default: state_n = S_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_SYNC;
            sync_cnt  <= '0;
            res_valid <= 1'b0;
            res_o     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            state <= state_n;
            if (state == S_SYNC && sync_cnt != SYNC_LAST) begin
                sync_cnt <= sync_cnt + 1'b1;
            end
            if (load_ops) begin
                mul_a <= head_a;
                mul_b <= head_b;
            end
            if (capture) begin
                res_o     <= mul_o;
                res_valid <= 1'b1;
            end else if (zero_wr) begin
                res_o     <= '0;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter WIDTH, default 16 (from package), operand width; result width OUT_WIDTH = 2*WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_a input WIDTH, in_b input WIDTH: operand push handshake.
REQ-006 SHALL have ports res_valid output 1, res_ready input 1, res_o output OUT_WIDTH: product pop handshake.
REQ-007 SHALL have ports mul_in_valid output 1, mul_a output WIDTH, mul_b output WIDTH: drive the shift-and-add multiplier's in_valid/a/b.
REQ-008 SHALL have ports mul_o input OUT_WIDTH, mul_out_valid input 1: receive the multiplier's o/out_valid.
REQ-009 SHALL have port seq_busy  output 1  high whenever state is not IDLE or FIFO is non-empty.

Function
REQ-010 SHALL push {in_a,in_b} into the FIFO on a cycle with in_valid && in_ready; in_ready = !fifo_full.
REQ-011 SHALL NOT bypass the FIFO: data pushed into an empty FIFO is issuable no earlier than the next cycle.
REQ-012 SHALL implement states SYNC, IDLE, ISSUE, WAIT, DRAIN.
REQ-013 SYNC: count SYNC_CYCLES (= WIDTH+4) cycles ignoring mul_out_valid, then go to IDLE.
REQ-014 IDLE: when FIFO non-empty and result slot empty, pop head, load mul_a/mul_b, go to ISSUE.
REQ-015 ISSUE: assert mul_in_valid for exactly this one cycle, then go to WAIT; mul_in_valid SHALL be 0 in every other state.
REQ-016 WAIT: on first cycle with mul_out_valid=1, capture mul_o into result slot, set res_valid, go to DRAIN.
REQ-017 DRAIN: stay while mul_out_valid=1 (multiplier holds out_valid up to 2 cycles); go to IDLE on first cycle with it 0; never issue from DRAIN.
REQ-018 Result slot SHALL hold res_o stable while res_valid && !res_ready; cleared on res_valid && res_ready.
REQ-019 Issue SHALL stall in IDLE while the result slot is full, including the cycle it is being popped (pop and capture never coincide).
REQ-020 Products SHALL leave in push order; res_o = in_a*in_b, unsigned, full OUT_WIDTH, no truncation.
REQ-021 mul_a/mul_b SHALL hold last issued operands outside ISSUE.

Reset
REQ-022 On rst: FIFO empty, in_ready=0 during the rst cycle, res_valid=0, res_o=0, mul_in_valid=0, mul_a=mul_b=0, seq_busy=1, state=SYNC, SYNC counter=0.
REQ-023 Reset mid-operation SHALL discard FIFO contents and any in-flight product; the multiplier has no reset, so SYNC guarantees its stale out_valid has expired before the next issue.

Configuration
REQ-024 Macro MUL_SEQ_ZERO_BYPASS_EN defined: in IDLE with slot empty and head a==0 or b==0, pop head and write res_o=0, res_valid=1 in the same cycle without issuing; next head usable the following cycle.
REQ-025 Macro undefined: every operand pair, zeros included, goes through ISSUE/WAIT/DRAIN.

Structure
REQ-026 Package mul_pkg SHALL hold WIDTH_LOG=4, WIDTH, OUT_WIDTH, SYNC_CYCLES, and the state enum type.
REQ-027 Operand FIFO SHALL be sub-module mul_seq_fifo (sync, DEPTH entries, full/empty, wrap-around pointers with extra MSB).

Verification
REQ-028 Single op: after SYNC, push a=3,b=5 -> exactly one mul_in_valid pulse, res_valid with res_o=15; one product per push.
REQ-029 Back-to-back: push (0xFFFF,0xFFFF),(2,7),(1,1) with res_ready=1 -> res_o 0xFFFE0001, 14, 1 in order; never two mul_in_valid without an intervening mul_out_valid fall.
REQ-030 Backpressure: res_ready=0, push 5 pairs with DEPTH=4 -> in_ready=0 after 4 buffered + 1 in flight/slot; res_o stable; release -> all 5 products, none lost.
REQ-031 Out_valid stretch: pair (9,1) -> multiplier out_valid high 2 cycles -> exactly one captured product 9, DRAIN held both cycles.
REQ-032 Zero operand: push (0,1234) -> res_o=0; with MUL_SEQ_ZERO_BYPASS_EN no mul_in_valid pulse, without it exactly one.
REQ-033 Reset mid-op: rst during WAIT of (0xABCD,0x1234) -> res_valid=0, 20-cycle SYNC, late mul_out_valid ignored, next push (4,4) -> res_o=16.
